// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Provides the address/instruction word types and the word-align helper.
package if_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] inst_word_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic addr_t word_align(input addr_t a);
        return a & ~addr_t'(3);
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory read bus: request/grant plus in-order response.
// master: imem_req, imem_addr out; imem_gnt, imem_rvalid, imem_rdata in.
interface if_fetch_ctrl_if;
    import if_pkg::*;

    logic       imem_req;
    addr_t      imem_addr;
    logic       imem_gnt;
    logic       imem_rvalid;
    inst_word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_rbuf.sv
// Response buffer: DEPTH x 32 synchronous FIFO, flush beats push.
// Ports: flush/push/pop controls, wdata in, rdata (head), count, empty.
module if_fetch_rbuf
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  inst_word_t                 wdata,
    output inst_word_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    inst_word_t    mem_q [DEPTH];

    logic do_push, do_pop, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A full buffer may still take a push when the head leaves the same cycle.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push & ~flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch request engine: issues word reads, buffers responses, feeds if_fifo.
// Ports: clk/rstb, jmp/jmp_addr redirect, imem master bus, fifo write side.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter addr_t RESET_PC    = RESET_PC_DEFAULT,
    parameter int    RBUF_DEPTH  = 4,
    parameter int    MAX_PENDING = 4
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            jmp,
    input  addr_t           jmp_addr,
    if_fetch_ctrl_if.master imem,
    input  logic            fifo_full,
    output logic            fifo_wr_en,
    output inst_word_t      fifo_wr_data,
    output logic            fifo_jmp,
    output logic            fifo_jmp_addr_bit1
);

    localparam int PW = $clog2(MAX_PENDING+1);
    localparam int CW = $clog2(RBUF_DEPTH+1);
    localparam int SW = ((PW > CW) ? PW : CW) + 1;

    localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

    addr_t         fetch_addr_q, fetch_addr_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [PW-1:0] discard_q, discard_d;
    logic          run_q;

    logic [CW-1:0] rbuf_count;
    logic          rbuf_empty;
    inst_word_t    rbuf_head;

    logic          accept, rsp, drop, push, credit_ok;
    logic [SW-1:0] in_use;

    // Live responses still owed plus buffered words must fit in rbuf,
    // so a response can always be stored without back-pressure.
    assign in_use    = SW'(pending_q - discard_q) + SW'(rbuf_count);
    assign credit_ok = (in_use < SW'(RBUF_DEPTH));

    // run_q keeps req low through reset and the first cycle after it.
    assign imem.imem_req  = run_q & ~jmp & (pending_q < MAX_P) & credit_ok;
    assign imem.imem_addr = fetch_addr_q;

    assign fifo_jmp           = jmp;
    assign fifo_jmp_addr_bit1 = jmp_addr[1];
    assign fifo_wr_en         = ~jmp & ~rbuf_empty & ~fifo_full;
    assign fifo_wr_data       = rbuf_head;

    always_comb begin
        accept = imem.imem_req & imem.imem_gnt;
        rsp    = imem.imem_rvalid;
        drop   = rsp & (jmp | (discard_q != '0));
        push   = rsp & ~drop;

        fetch_addr_d = fetch_addr_q;
        if (jmp) begin
            fetch_addr_d = word_align(jmp_addr);
        end else if (accept) begin
            fetch_addr_d = fetch_addr_q + addr_t'(4);
        end

        pending_d = pending_q + PW'(accept) - PW'(rsp);

        // A redirect marks every request still outstanding after this
        // cycle as stale; recomputing from pending avoids double counts.
        discard_d = discard_q;
        if (jmp) begin
            discard_d = pending_q - PW'(rsp);
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fetch_addr_q <= word_align(RESET_PC);
            pending_q    <= '0;
            discard_q    <= '0;
            run_q        <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pending_q    <= pending_d;
            discard_q    <= discard_d;
            run_q        <= 1'b1;
        end
    end

    if_fetch_rbuf #(
        .DEPTH(RBUF_DEPTH)
    ) u_rbuf (
        .clk  (clk),
        .rstb (rstb),
        .flush(jmp),
        .push (push),
        .pop  (fifo_wr_en),
        .wdata(imem.imem_rdata),
        .rdata(rbuf_head),
        .count(rbuf_count),
        .empty(rbuf_empty)
    );

endmodule
